// File: rtl/isp_bayer_correct_pipe.sv
// Per-Bayer-phase black-level subtraction and fixed-point gain with rounding and
// saturation on LANES pixels per beat; frame-shadowed parameters and clip counting.
module isp_bayer_correct_pipe #(
   parameter int PIX_W     = 12,
   parameter int LANES     = 2,
   parameter int GAIN_W    = 12,
   parameter int GAIN_FRAC = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   u_i_ready,
   output logic                   i_i_ready,
   input  logic [LANES*PIX_W-1:0] data_in,
   input  logic                   sof_in,
   input  logic                   eol_in,
   input  logic [4*PIX_W-1:0]     offset_in,
   input  logic [4*GAIN_W-1:0]    gain_in,
   input  logic [1:0]             pattern_in,
   input  logic                   bypass_in,
   input  logic                   u_r_ready,
   output logic                   i_r_ready,
   output logic [LANES*PIX_W-1:0] data_out,
   output logic                   sof_out,
   output logic                   eol_out,
   output logic [15:0]            frame_clips
);

   localparam int PROD_W = PIX_W + GAIN_W;
   localparam int CNT_W  = $clog2(LANES + 1);
   localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1) << GAIN_FRAC;
   localparam logic [PROD_W:0]   HALF     = (PROD_W+1)'(1) << (GAIN_FRAC - 1);
   localparam bit LANES_ODD = (LANES % 2) == 1;

   logic adv, acc, out_xfer;
   assign adv       = !i_r_ready || u_r_ready;
   assign i_i_ready = adv && !reset;
   assign acc       = u_i_ready && i_i_ready;
   assign out_xfer  = i_r_ready && u_r_ready;

   logic [4*PIX_W-1:0]  off_reg;
   logic [4*GAIN_W-1:0] gain_reg;
   logic [1:0]          pat_reg;
   logic                byp_reg;
   logic                row_par_reg;
   logic [15:0]         col_cnt_reg;

   // A sof beat uses its own freshly presented parameters and restarts at (0,0).
   logic [4*PIX_W-1:0]  off_cur;
   logic [4*GAIN_W-1:0] gain_cur;
   logic [1:0]          pat_cur;
   logic                byp_cur, row_cur;
   logic [15:0]         col_cur;
   assign off_cur  = sof_in ? offset_in  : off_reg;
   assign gain_cur = sof_in ? gain_in    : gain_reg;
   assign pat_cur  = sof_in ? pattern_in : pat_reg;
   assign byp_cur  = sof_in ? bypass_in  : byp_reg;
   assign row_cur  = sof_in ? 1'b0       : row_par_reg;
   assign col_cur  = sof_in ? 16'd0      : col_cnt_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         off_reg     <= '0;
         gain_reg    <= {4{GAIN_ONE}};
         pat_reg     <= 2'd0;
         byp_reg     <= 1'b0;
         row_par_reg <= 1'b0;
         col_cnt_reg <= 16'd0;
      end else if (acc) begin
         off_reg     <= off_cur;
         gain_reg    <= gain_cur;
         pat_reg     <= pat_cur;
         byp_reg     <= byp_cur;
         row_par_reg <= row_cur ^ eol_in;
         col_cnt_reg <= eol_in ? 16'd0 : col_cur + 16'd1;
      end
   end

   logic v1, v2, v3, sof1, sof2, sof3, eol1, eol2, eol3;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         {v1, v2, v3}       <= 3'b000;
         {sof1, sof2, sof3} <= 3'b000;
         {eol1, eol2, eol3} <= 3'b000;
      end else if (adv) begin
         v1   <= acc;
         sof1 <= acc && sof_in;
         eol1 <= acc && eol_in;
         v2   <= v1;  sof2 <= sof1;  eol2 <= eol1;
         v3   <= v2;  sof3 <= sof2;  eol3 <= eol2;
      end
   end
   assign i_r_ready = v3;
   assign sof_out   = sof3;
   assign eol_out   = eol3;

   logic clip3 [LANES];

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic              col_par;
      logic [1:0]        phase;
      logic [PIX_W-1:0]  pix, off_sel, d_next, d1, out3;
      logic [GAIN_W-1:0] gain_sel, g1;
      logic [PROD_W-1:0] p2;
      logic [PROD_W:0]   rnd, scaled;
      logic              clip_next;

      assign pix      = data_in[gi*PIX_W +: PIX_W];
      assign col_par  = ((gi % 2) == 1) ^ (LANES_ODD & col_cur[0]);
      assign phase    = {row_cur ^ pat_cur[1], col_par ^ pat_cur[0]};
      assign off_sel  = off_cur[phase*PIX_W +: PIX_W];
      // Bypass rides the arithmetic path with unity gain, so latency matches and nothing clips.
      assign gain_sel = byp_cur ? GAIN_ONE : gain_cur[phase*GAIN_W +: GAIN_W];
      assign d_next   = byp_cur ? pix : ((pix > off_sel) ? pix - off_sel : '0);

      assign rnd       = {1'b0, p2} + HALF;
      assign scaled    = rnd >> GAIN_FRAC;
      assign clip_next = |scaled[PROD_W:PIX_W];

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            d1        <= '0;
            g1        <= '0;
            p2        <= '0;
            out3      <= '0;
            clip3[gi] <= 1'b0;
         end else if (adv) begin
            d1        <= d_next;
            g1        <= gain_sel;
            p2        <= PROD_W'(d1) * PROD_W'(g1);
            out3      <= clip_next ? '1 : scaled[PIX_W-1:0];
            clip3[gi] <= clip_next;
         end
      end

      assign data_out[gi*PIX_W +: PIX_W] = out3;
   end

   logic [CNT_W-1:0] nclip;
   always_comb begin
      nclip = '0;
      for (int i = 0; i < LANES; i++) nclip = nclip + CNT_W'(clip3[i]);
   end

   logic [15:0] clip_cnt_reg;
   logic [16:0] clip_sum;
   assign clip_sum = {1'b0, clip_cnt_reg} + 17'(nclip);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clip_cnt_reg <= 16'd0;
         frame_clips  <= 16'd0;
      end else if (out_xfer) begin
         if (sof_out) begin
            frame_clips  <= clip_cnt_reg;
            clip_cnt_reg <= 16'(nclip);
         end else begin
            clip_cnt_reg <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
         end
      end
   end

endmodule

// File: tb/tb_isp_bayer_correct_pipe.sv
// Scoreboard bench: driver pushes reference-model results, monitor pops on output transfers.
module tb_isp_bayer_correct_pipe;

   localparam int PIX_W = 12, LANES = 2, GAIN_W = 12, GAIN_FRAC = 8;
   localparam int DW = LANES * PIX_W;

   logic          clock = 1'b0, reset;
   logic          u_i_ready, i_i_ready, u_r_ready, i_r_ready;
   logic [DW-1:0] data_in, data_out;
   logic          sof_in, eol_in, sof_out, eol_out, bypass_in;
   logic [47:0]   offset_in, gain_in;
   logic [1:0]    pattern_in;
   logic [15:0]   frame_clips;

   isp_bayer_correct_pipe #(.PIX_W(PIX_W), .LANES(LANES), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)) dut (
      .clock(clock), .reset(reset), .u_i_ready(u_i_ready), .i_i_ready(i_i_ready),
      .data_in(data_in), .sof_in(sof_in), .eol_in(eol_in), .offset_in(offset_in),
      .gain_in(gain_in), .pattern_in(pattern_in), .bypass_in(bypass_in),
      .u_r_ready(u_r_ready), .i_r_ready(i_r_ready), .data_out(data_out),
      .sof_out(sof_out), .eol_out(eol_out), .frame_clips(frame_clips));

   always #5 clock = ~clock;

   typedef struct {
      logic [DW-1:0] data;
      bit            sof, eol;
      int            clips;
   } exp_t;

   exp_t q[$];
   int errors = 0, checks = 0;
   int m_off[4], m_gain[4], m_pat, m_byp, m_row, m_col;
   int m_cnt = 0, m_fc = 0;
   bit mon_en = 0;
   int rr_mode = 0;   // 0: always ready, 1: random, 2: never ready
   // Colour found at (row%2, col%2) for each pattern: index 0=R 1=Gr 2=Gb 3=B.
   int phase_tab[4][4] = '{'{0, 1, 2, 3}, '{1, 0, 3, 2}, '{2, 3, 0, 1}, '{3, 2, 1, 0}};

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [47:0] pk4(input int r, input int gr, input int gb, input int b);
      logic [11:0] a0, a1, a2, a3;
      a0 = r[11:0]; a1 = gr[11:0]; a2 = gb[11:0]; a3 = b[11:0];
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [DW-1:0] pk2(input int l0, input int l1);
      logic [11:0] a0, a1;
      a0 = l0[11:0]; a1 = l1[11:0];
      return {a1, a0};
   endfunction

   task automatic model_defaults();
      for (int p = 0; p < 4; p++) begin m_off[p] = 0; m_gain[p] = 1 << GAIN_FRAC; end
      m_pat = 0; m_byp = 0; m_row = 0; m_col = 0;
   endtask

   task automatic model_accept();
      exp_t e;
      int pix, col, ph, d, r;
      if (sof_in) begin
         for (int p = 0; p < 4; p++) begin
            m_off[p]  = int'(offset_in[p*12 +: 12]);
            m_gain[p] = int'(gain_in[p*12 +: 12]);
         end
         m_pat = int'(pattern_in); m_byp = int'(bypass_in); m_row = 0; m_col = 0;
      end
      e.data = '0; e.clips = 0; e.sof = sof_in; e.eol = eol_in;
      for (int l = 0; l < LANES; l++) begin
         pix = int'(data_in[l*12 +: 12]);
         col = m_col + l;
         ph  = phase_tab[m_pat][(m_row % 2) * 2 + (col % 2)];
         if (m_byp != 0) r = pix;
         else begin
            d = pix - m_off[ph];
            if (d < 0) d = 0;
            r = (d * m_gain[ph] + (1 << (GAIN_FRAC - 1))) / (1 << GAIN_FRAC);
            if (r > 4095) begin r = 4095; e.clips++; end
         end
         e.data[l*12 +: 12] = r[11:0];
      end
      q.push_back(e);
      if (eol_in) begin m_row = 1 - m_row; m_col = 0; end
      else m_col += LANES;
   endtask

   function automatic logic rr_value();
      if (rr_mode == 0) return 1'b1;
      if (rr_mode == 2) return 1'b0;
      return $urandom_range(0, 3) != 0;
   endfunction

   task automatic send(input logic [DW-1:0] d, input bit s, input bit e);
      bit done = 0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clock); #1;
         u_i_ready = 1'b1; data_in = d; sof_in = s; eol_in = e; u_r_ready = rr_value();
         #1;
         if (i_i_ready) begin model_accept(); done = 1; end
      end
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock); #1;
         u_i_ready = 1'b0; sof_in = 1'b0; eol_in = 1'b0; u_r_ready = rr_value();
      end
   endtask

   // Follows a single beat into an empty pipe: valid must appear exactly on the third cycle.
   task automatic expect3(input string name, input logic [DW-1:0] d, input bit s);
      idle(1); #1 chk({name, "_lat1"}, i_r_ready, 0);
      idle(1); #1 chk({name, "_lat2"}, i_r_ready, 0);
      idle(1); #1 chk({name, "_lat3"}, i_r_ready, 1);
      chk({name, "_data"}, data_out, d);
      chk({name, "_sof"}, sof_out, s);
   endtask

   task automatic drain();
      rr_mode = 0;
      for (int i = 0; i < 300 && (q.size() != 0 || i_r_ready); i++) idle(1);
      #2 chk("drain_empty", q.size(), 0);
   endtask

   always @(negedge clock) begin
      exp_t e;
      #2;
      if (mon_en) begin
         chk("frame_clips", frame_clips, m_fc);
         if (i_r_ready && u_r_ready) begin
            if (q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
               e = q.pop_front();
               $display("out beat data=%h sof=%0b eol=%0b clips=%0d", data_out, sof_out, eol_out, e.clips);
               chk("data_out", data_out, e.data);
               chk("sof_out", sof_out, e.sof);
               chk("eol_out", eol_out, e.eol);
               if (e.sof) begin m_fc = m_cnt; m_cnt = e.clips; end
               else begin m_cnt += e.clips; if (m_cnt > 65535) m_cnt = 65535; end
            end
         end
      end
   end

   initial begin
      logic [DW-1:0] snap;
      reset = 1'b1; u_i_ready = 1'b0; data_in = '0; sof_in = 1'b0; eol_in = 1'b0;
      offset_in = '0; gain_in = pk4(256, 256, 256, 256); pattern_in = 2'd0; bypass_in = 1'b0;
      u_r_ready = 1'b1;
      model_defaults();
      #12;
      chk("rst_i_i_ready", i_i_ready, 0);
      chk("rst_i_r_ready", i_r_ready, 0);
      @(negedge clock); #3 reset = 1'b0;
      #1 chk("post_rst_i_i_ready", i_i_ready, 1);
      mon_en = 1;

      // Basic correction
      offset_in = pk4(64, 32, 0, 0); gain_in = pk4(256, 512, 256, 256);
      send(pk2(100, 200), 1, 0);
      expect3("basic", pk2(36, 336), 1);

      // Arithmetic edges; eol on beat 0 moves beat 1 onto the Gb/B row
      offset_in = pk4(64, 0, 0, 0); gain_in = pk4(256, 512, 128, 256);
      send(pk2(10, 4000), 1, 1);
      expect3("edge0", pk2(0, 4095), 1);
      send(pk2(3, 1000), 0, 0);
      expect3("edge1", pk2(2, 1000), 0);

      // Bypass frame; its sof reports the single clip of the previous frame
      offset_in = pk4(50, 50, 50, 50); gain_in = pk4(512, 512, 512, 512); bypass_in = 1'b1;
      send(pk2(4000, 5), 1, 0);
      expect3("bypass", pk2(4000, 5), 1);
      idle(1); #1 chk("clips_after_edges", frame_clips, 1);
      send(pk2(4095, 4095), 0, 0);
      drain();

      // Next frame: bypass frame counted nothing
      bypass_in = 1'b0; offset_in = pk4(10, 10, 10, 10); gain_in = pk4(256, 256, 256, 256);
      send(pk2(100, 100), 1, 0);
      expect3("newframe", pk2(90, 90), 1);
      idle(1); #1 chk("clips_after_bypass", frame_clips, 0);

      // Shadowing: mid-frame parameter changes are ignored
      offset_in = pk4(500, 500, 500, 500); gain_in = pk4(1024, 1024, 1024, 1024); pattern_in = 2'd3;
      send(pk2(100, 100), 0, 0);
      expect3("shadow", pk2(90, 90), 0);

      // BGGR: row 0 lane 0 is B
      offset_in = pk4(1, 2, 3, 100); gain_in = pk4(256, 256, 256, 512); pattern_in = 2'd3;
      send(pk2(300, 300), 1, 0);
      expect3("bggr", pk2(400, 297), 1);

      // RGGB second row after eol uses Gb and B gains
      offset_in = pk4(0, 0, 0, 0); gain_in = pk4(256, 256, 512, 768); pattern_in = 2'd0;
      send(pk2(10, 20), 1, 1);
      expect3("row0", pk2(10, 20), 1);
      send(pk2(100, 100), 0, 0);
      expect3("row1", pk2(200, 300), 0);
      drain();

      // Backpressure: fill the pipe then hold downstream for 5 cycles
      gain_in = pk4(256, 256, 256, 256);
      rr_mode = 2;
      send(pk2(11, 12), 1, 0);
      send(pk2(13, 14), 0, 0);
      send(pk2(15, 16), 0, 1);
      snap = '0;
      for (int i = 0; i < 5; i++) begin
         idle(1); #1;
         if (i == 0) snap = data_out;
         chk("bp_valid", i_r_ready, 1);
         chk("bp_i_i_ready", i_i_ready, 0);
         chk("bp_stable", data_out, snap);
      end
      chk("bp_first_beat", snap, pk2(11, 12));
      drain();

      // Randomised traffic with random backpressure
      rr_mode = 1;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else begin
            bit s;
            s = ($urandom_range(0, 29) == 0);
            if (s) begin
               offset_in = pk4($urandom_range(0, 400), $urandom_range(0, 400),
                               $urandom_range(0, 400), $urandom_range(0, 400));
               gain_in = pk4($urandom_range(0, 4095), $urandom_range(0, 4095),
                             $urandom_range(0, 4095), $urandom_range(0, 4095));
               pattern_in = 2'($urandom_range(0, 3));
               bypass_in = ($urandom_range(0, 7) == 0);
            end else if ($urandom_range(0, 9) == 0) begin
               offset_in = pk4($urandom_range(0, 4095), 7, 7, 7);
            end
            send(pk2($urandom_range(0, 4095), $urandom_range(0, 4095)), s, $urandom_range(0, 4) == 0);
         end
      end

      // Asynchronous reset mid-stream
      send(pk2(1000, 2000), 0, 0);
      send(pk2(3000, 4000), 0, 0);
      @(negedge clock); #3;
      mon_en = 0;
      reset = 1'b1;
      #1;
      chk("midrst_i_r_ready", i_r_ready, 0);
      chk("midrst_data_out", data_out, 0);
      chk("midrst_frame_clips", frame_clips, 0);
      chk("midrst_sof_out", sof_out, 0);
      chk("midrst_i_i_ready", i_i_ready, 0);
      q.delete(); m_cnt = 0; m_fc = 0; model_defaults();
      u_i_ready = 1'b0;
      @(negedge clock); #3 reset = 1'b0;
      #1 chk("midrst_release_i_i_ready", i_i_ready, 1);
      mon_en = 1;

      // Pre-sof beat after reset uses default shadows at (0,0)
      rr_mode = 0;
      offset_in = pk4(99, 99, 99, 99); gain_in = pk4(1, 1, 1, 1); pattern_in = 2'd2;
      send(pk2(100, 200), 0, 0);
      expect3("default_shadow", pk2(100, 200), 0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
